// File: rtl/operand_entry_fsm_pkg.sv
// Shared definitions for the operand-entry front end: FSM state encodings
// and debounce lengths for silicon and for simulation.
package operand_entry_fsm_pkg;

  typedef enum logic [1:0] {
    ST_ENTER_X = 2'b00,
    ST_ENTER_Y = 2'b01,
    ST_HOLD    = 2'b10,
    ST_UNUSED  = 2'b11
  } entry_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-FF synchronizer, saturating debounce
// counter, stable-level register and a registered one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic MAX10_CLK1_50,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        // Old level 1 means this flip is a fresh press; a release stays silent.
        stable <= sync2;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_entry_fsm.sv
// Three-step operand entry (X, then Y + op select, then hold) driven by a
// debounced ENTER key; every output is a register feeding the adder stage.
module operand_entry_fsm
  import operand_entry_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset_n,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] inputx,
  output logic [3:0] inputy,
  output logic       sub,
  output logic       operands_valid,
  output logic [1:0] entry_state
);

  entry_state_t state;
  entry_state_t state_nxt;
  logic         press;
  logic         cap_x;
  logic         cap_y;
  logic         clr_valid;

  // KEY[0] and SW[8:4] have no function on this board configuration.
  logic unused_inputs;
  assign unused_inputs = ^{KEY[0], SW[8:4]};

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset_n      (reset_n),
    .key_n        (KEY[1]),
    .press        (press)
  );

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) state <= ST_ENTER_X;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_x     = 1'b0;
    cap_y     = 1'b0;
    clr_valid = 1'b0;
    case (state)
      ST_ENTER_X: if (press) begin
        cap_x     = 1'b1;
        state_nxt = ST_ENTER_Y;
      end
      ST_ENTER_Y: if (press) begin
        cap_y     = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: if (press) begin
        clr_valid = 1'b1;
        state_nxt = ST_ENTER_X;
      end
      default: begin
        clr_valid = 1'b1;
        state_nxt = ST_ENTER_X;
      end
    endcase
  end

  // Switches are only looked at in the single cycle the press pulse is high.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      inputx         <= 4'h0;
      inputy         <= 4'h0;
      sub            <= 1'b0;
      operands_valid <= 1'b0;
    end else begin
      if (cap_x) inputx <= SW[3:0];
      if (cap_y) begin
        inputy         <= SW[3:0];
        sub            <= SW[9];
        operands_valid <= 1'b1;
      end
      if (clr_valid) operands_valid <= 1'b0;
    end
  end

  assign entry_state = state;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a 4-cycle debounce.
module tb_operand_entry_fsm;
  import operand_entry_fsm_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [9:0] sw;
  logic [1:0] key;
  logic [3:0] inputx;
  logic [3:0] inputy;
  logic       sub;
  logic       operands_valid;
  logic [1:0] entry_state;

  int n_checks;
  int n_fail;

  operand_entry_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset_n       (reset_n),
    .SW            (sw),
    .KEY           (key),
    .inputx        (inputx),
    .inputy        (inputy),
    .sub           (sub),
    .operands_valid(operands_valid),
    .entry_state   (entry_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] x, input logic [3:0] y,
                             input logic s, input logic v, input logic [1:0] st);
    chk({tag, ".inputx"}, 32'(inputx), 32'(x));
    chk({tag, ".inputy"}, 32'(inputy), 32'(y));
    chk({tag, ".sub"}, 32'(sub), 32'(s));
    chk({tag, ".valid"}, 32'(operands_valid), 32'(v));
    chk({tag, ".state"}, 32'(entry_state), 32'(st));
  endtask

  // Hold ENTER low for a number of cycles, release, then let the release settle.
  task automatic press_key(input int hold);
    key[1] = 1'b0;
    repeat (hold) step();
    key[1] = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    sw       = 10'h3FF;
    key      = 2'b11;

    // Reset with all switches high
    repeat (3) step();
    chk_outputs("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    reset_n = 1'b1;
    step();

    // X = 5: capture lands on edge 7 counted from the first low sample
    sw     = 10'h005;
    key[1] = 1'b0;
    repeat (7) step();
    chk("x_not_yet", 32'(inputx), 32'h0);
    chk("x_state_not_yet", 32'(entry_state), 32'h0);
    step();
    chk("x_captured", 32'(inputx), 32'h5);
    chk("x_state", 32'(entry_state), 32'h1);
    repeat (2) step();
    key[1] = 1'b1;
    repeat (12) step();
    chk("after_release_state", 32'(entry_state), 32'h1);

    // Y = B, subtract
    sw = 10'h20B;
    press_key(10);
    chk_outputs("y_sub", 4'h5, 4'hB, 1'b1, 1'b1, 2'b10);

    // Switch activity with no press pending
    sw = 10'h3FF;
    repeat (5) step();
    sw = 10'h000;
    repeat (5) step();
    chk_outputs("sw_isolation", 4'h5, 4'hB, 1'b1, 1'b1, 2'b10);

    // Press in HOLD wraps, keeping the captured operands
    sw = 10'h3F0;
    press_key(10);
    chk_outputs("wrap", 4'h5, 4'hB, 1'b1, 1'b0, 2'b00);

    // Bounce: 2-cycle glitches never reach the debounce threshold
    sw = 10'h009;
    for (int i = 0; i < 5; i++) begin
      key[1] = 1'b0;
      repeat (2) step();
      key[1] = 1'b1;
      repeat (2) step();
    end
    chk("bounce_state", 32'(entry_state), 32'h0);
    chk("bounce_x", 32'(inputx), 32'h5);
    key[1] = 1'b0;
    repeat (8) step();
    key[1] = 1'b1;
    repeat (12) step();
    chk("settle_state", 32'(entry_state), 32'h1);
    chk("settle_x", 32'(inputx), 32'h9);

    // Reset coincident with press in ENTER_Y
    sw     = 10'h207;
    key[1] = 1'b0;
    repeat (7) step();
    chk("press_pulse_ey", 32'(dut.u_debounce.press), 32'h1);
    reset_n = 1'b0;
    step();
    chk_outputs("reset_priority", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

    // Key kept low across reset release
    sw = 10'h00C;
    step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("held_no_press_early", 32'(dut.u_debounce.press), 32'h0);
    step();
    chk("held_press", 32'(dut.u_debounce.press), 32'h1);
    chk("held_x_not_yet", 32'(inputx), 32'h0);
    step();
    chk("held_x", 32'(inputx), 32'hC);
    chk("held_state", 32'(entry_state), 32'h1);
    sw = 10'h201;
    repeat (20) step();
    chk("held_no_second_state", 32'(entry_state), 32'h1);
    chk("held_no_second_y", 32'(inputy), 32'h0);
    chk("held_press_low", 32'(dut.u_debounce.press), 32'h0);
    key[1] = 1'b1;
    repeat (12) step();
    chk("held_release_state", 32'(entry_state), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
